// File: rtl/ysyx_23060171_pkg.sv
// Shared types for the ysyx_23060171 memory arbiter: FSM states, owner codes and default widths.
package ysyx_23060171_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_23060171_arb_pick.sv
// Two-way combinational picker between IFU and LSU requests.
// Tie policy: round-robin when YSYX_23060171_ARB_RR_EN is defined, otherwise LSU fixed priority.
module ysyx_23060171_arb_pick
    import ysyx_23060171_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     last_grant,
    output logic [1:0] grant,
    output owner_e     owner
);

    logic tie_to_lsu;

`ifdef YSYX_23060171_ARB_RR_EN
    assign tie_to_lsu = (last_grant == OWN_IFU);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_to_lsu        = 1'b1;
`endif

    // grant[0] = IFU, grant[1] = LSU
    always_comb begin
        grant = 2'b00;
        owner = OWN_IFU;
        if (lsu_valid && (!ifu_valid || tie_to_lsu)) begin
            grant = 2'b10;
            owner = OWN_LSU;
        end else if (ifu_valid) begin
            grant = 2'b01;
            owner = OWN_IFU;
        end
    end

endmodule

// File: rtl/ysyx_23060171_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction at a time (IDLE -> REQ -> RESP).
// Tie policy selected by YSYX_23060171_ARB_RR_EN (round-robin) vs. default LSU priority.
module ysyx_23060171_mem_arbiter
    import ysyx_23060171_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    arb_state_e state, state_nxt;
    owner_e     owner_q, pick_owner, last_grant;
    logic [1:0] grant;
    logic       grant_hs;

    ysyx_23060171_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .owner      (pick_owner)
    );

    // picker only grants valid requesters, so a grant in IDLE is the handshake
    assign grant_hs = (state == IDLE) && (grant != 2'b00);

`ifdef YSYX_23060171_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           last_grant <= OWN_IFU;
        else if (grant_hs) last_grant <= pick_owner;
    end
`else
    assign last_grant = OWN_IFU;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_hs) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RESP;
            RESP:    if (mem_resp_valid && mem_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_hs) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_LSU) begin
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else begin
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end
        end
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                ifu_req_ready = grant[0];
                lsu_req_ready = grant[1];
            end
            REQ: begin
                mem_req_valid = 1'b1;
                busy          = 1'b1;
            end
            RESP: begin
                busy = 1'b1;
                if (owner_q == OWN_LSU) begin
                    lsu_resp_valid = mem_resp_valid;
                    mem_resp_ready = lsu_resp_ready;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    mem_resp_ready = ifu_resp_ready;
                end
            end
            default: ;
        endcase
    end

    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule
